// File: rtl/inter_layer_block_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// inter_layer_block_scheduler_pkg
// Shared types for the inter-layer block scheduler: block-pair direction
// encodings, compute-unit encodings, scheduler FSM states and the tie-break
// helper used when both blocks carry the same workload.
// -----------------------------------------------------------------------------
package inter_layer_block_scheduler_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Direction of block0 / block1 (first word names block0).
    typedef enum logic [1:0] {
        BT_FORWARD_FORWARD   = 2'd0,
        BT_FORWARD_BACKWARD  = 2'd1,
        BT_BACKWARD_FORWARD  = 2'd2,
        BT_BACKWARD_BACKWARD = 2'd3
    } block_type_e;

    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_NPU  = 2'd1,
        UNIT_CIM  = 2'd2
    } unit_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD0  = 3'd1,
        ST_LOAD1  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_e;

    // On equal workloads the backward-direction block takes the NPU. Only the
    // forward/backward pair puts the backward block in slot 1; FF and BB fall
    // back to block0, and BF already has block0 backward.
    function automatic logic tie_prefers_block1(input block_type_e bt);
        return (bt == BT_FORWARD_BACKWARD);
    endfunction

endpackage

// File: rtl/inter_layer_config_fetch.sv
// -----------------------------------------------------------------------------
// inter_layer_config_fetch
// Single-word read engine for the configuration memory. A request pulse
// launches one read; address and valid are held until the memory returns
// ready, at which edge the word is handed back and valid drops.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_i, addr_i        start a read of addr_i (ignored while busy)
//   mem_addr_o           read address (0 whenever no read is outstanding)
//   mem_valid_o          read request
//   mem_data_i           read data from memory
//   mem_ready_i          read data valid / accept
//   busy_o               a read is outstanding
//   done_o, data_o       handshake completes at the coming edge; data_o is
//                        the word to capture on that edge
// -----------------------------------------------------------------------------
module inter_layer_config_fetch
    import inter_layer_block_scheduler_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_valid_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (r_valid && mem_ready_i) begin
            // Address returns to zero together with valid.
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (req_i && !r_valid) begin
            r_valid <= 1'b1;
            r_addr  <= addr_i;
        end
    end

    assign mem_addr_o  = r_addr;
    assign mem_valid_o = r_valid;
    assign busy_o      = r_valid;
    // Ready without an outstanding request is meaningless and ignored.
    assign done_o      = r_valid && mem_ready_i;
    assign data_o      = mem_data_i;

endmodule

// File: rtl/inter_layer_block_scheduler.sv
// -----------------------------------------------------------------------------
// inter_layer_block_scheduler
// Fetches the workload word of two adjacent layer blocks from configuration
// memory and assigns each block to the NPU or the in-pipeline CIM.
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   npu_capability_i                   NPU workload budget
//   in_pipeline_cim_capability_i       CIM workload budget
//   config_mem_addr_o/_read_valid_o    read request to config memory
//   config_mem_read_data_i/_ready_i    read response
//   block_type_i                       direction pair of block0/block1
//   block{0,1}_start_i/_length_i       config address and layer count
//   schedule_valid_i/schedule_ready_o  request handshake (ready = idle)
//   block{0,1}_unit_o                  0 none, 1 NPU, 2 CIM
//   schedule_done_o                    one-cycle strobe when units update
// -----------------------------------------------------------------------------
module inter_layer_block_scheduler
    import inter_layer_block_scheduler_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] npu_capability_i,
    input  logic [DATA_W-1:0] in_pipeline_cim_capability_i,
    output logic [ADDR_W-1:0] config_mem_addr_o,
    output logic              config_mem_read_valid_o,
    input  logic [DATA_W-1:0] config_mem_read_data_i,
    input  logic              config_mem_read_ready_i,
    input  logic [1:0]        block_type_i,
    input  logic [ADDR_W-1:0] block0_start_i,
    input  logic [ADDR_W-1:0] block1_start_i,
    input  logic [31:0]       block0_length_i,
    input  logic [31:0]       block1_length_i,
    input  logic              schedule_valid_i,
    output logic              schedule_ready_o,
    output logic [1:0]        block0_unit_o,
    output logic [1:0]        block1_unit_o,
    output logic              schedule_done_o
);

    sched_state_e      r_state, w_state_next;
    block_type_e       r_type;
    logic [ADDR_W-1:0] r_start0, r_start1;
    logic              r_has0, r_has1;     // block has at least one layer
    logic [DATA_W-1:0] r_npu_cap, r_cim_cap;
    logic [DATA_W-1:0] r_w0, r_w1;
    unit_e             r_unit0, r_unit1;

    logic              w_fetch_req;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_fetch_busy, w_fetch_done;
    logic [DATA_W-1:0] w_fetch_data;

    unit_e             w_unit0, w_unit1;
    logic [DATA_W:0]   w_sum;
    logic              w_b1_npu;

    inter_layer_config_fetch u_fetch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (w_fetch_req),
        .addr_i      (w_fetch_addr),
        .mem_addr_o  (config_mem_addr_o),
        .mem_valid_o (config_mem_read_valid_o),
        .mem_data_i  (config_mem_read_data_i),
        .mem_ready_i (config_mem_read_ready_i),
        .busy_o      (w_fetch_busy),
        .done_o      (w_fetch_done),
        .data_o      (w_fetch_data)
    );

    // Next state and fetch request. The request is raised in the first cycle
    // of a LOAD state, so valid appears on the cycle after entry.
    always_comb begin
        w_state_next = r_state;
        w_fetch_req  = 1'b0;
        w_fetch_addr = r_start0;
        case (r_state)
            ST_IDLE:   if (schedule_valid_i) w_state_next = ST_LOAD0;
            ST_LOAD0: begin
                if (!r_has0) begin
                    w_state_next = ST_LOAD1;
                end else begin
                    w_fetch_req = !w_fetch_busy;
                    if (w_fetch_done) w_state_next = ST_LOAD1;
                end
            end
            ST_LOAD1: begin
                w_fetch_addr = r_start1;
                if (!r_has1) begin
                    w_state_next = ST_DECIDE;
                end else begin
                    w_fetch_req = !w_fetch_busy;
                    if (w_fetch_done) w_state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Unit decision. The sum is 33 bits so two large workloads cannot wrap
    // around and appear to fit the NPU budget.
    always_comb begin
        w_sum    = {1'b0, r_w0} + {1'b0, r_w1};
        w_b1_npu = (r_w1 > r_w0) || ((r_w1 == r_w0) && tie_prefers_block1(r_type));
        w_unit0  = UNIT_NPU;
        w_unit1  = UNIT_NPU;
        if (w_sum > {1'b0, r_npu_cap}) begin
            // The loser goes to CIM if it fits there, otherwise it queues
            // behind the winner on the NPU.
            if (w_b1_npu) begin
                w_unit0 = (r_w0 <= r_cim_cap) ? UNIT_CIM : UNIT_NPU;
            end else begin
                w_unit1 = (r_w1 <= r_cim_cap) ? UNIT_CIM : UNIT_NPU;
            end
        end
        if (!r_has0) w_unit0 = UNIT_NONE;
        if (!r_has1) w_unit1 = UNIT_NONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_type    <= BT_FORWARD_FORWARD;
            r_start0  <= '0;
            r_start1  <= '0;
            r_has0    <= 1'b0;
            r_has1    <= 1'b0;
            r_npu_cap <= '0;
            r_cim_cap <= '0;
            r_w0      <= '0;
            r_w1      <= '0;
            r_unit0   <= UNIT_NONE;
            r_unit1   <= UNIT_NONE;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    // Everything the run depends on is snapshotted here so
                    // later input changes cannot disturb it.
                    if (schedule_valid_i) begin
                        r_type    <= block_type_e'(block_type_i);
                        r_start0  <= block0_start_i;
                        r_start1  <= block1_start_i;
                        r_has0    <= (block0_length_i != '0);
                        r_has1    <= (block1_length_i != '0);
                        r_npu_cap <= npu_capability_i;
                        r_cim_cap <= in_pipeline_cim_capability_i;
                        r_w0      <= '0;
                        r_w1      <= '0;
                    end
                end
                ST_LOAD0:  if (r_has0 && w_fetch_done) r_w0 <= w_fetch_data;
                ST_LOAD1:  if (r_has1 && w_fetch_done) r_w1 <= w_fetch_data;
                ST_DECIDE: begin
                    r_unit0 <= w_unit0;
                    r_unit1 <= w_unit1;
                end
                default: ;
            endcase
        end
    end

    assign schedule_ready_o = (r_state == ST_IDLE);
    assign schedule_done_o  = (r_state == ST_DONE);
    assign block0_unit_o    = r_unit0;
    assign block1_unit_o    = r_unit1;

endmodule

// File: tb/tb_inter_layer_block_scheduler.sv
module tb_inter_layer_block_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npu_cap = '0, cim_cap = '0;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [1:0]  btype = '0;
    logic [31:0] s0 = '0, s1 = '0, l0 = '0, l1 = '0;
    logic        sched_valid = 1'b0;
    logic        sched_ready;
    logic [1:0]  unit0, unit1;
    logic        done;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    bit hold_ready = 1'b0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_addr [$];
    logic [3:0]  exp_units [$];

    bit          prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    logic [31:0] prev_addr = '0;

    inter_layer_block_scheduler dut (
        .clk_i                        (clk),
        .rst_i                        (rst),
        .npu_capability_i             (npu_cap),
        .in_pipeline_cim_capability_i (cim_cap),
        .config_mem_addr_o            (mem_addr),
        .config_mem_read_valid_o      (mem_valid),
        .config_mem_read_data_i       (mem_rdata),
        .config_mem_read_ready_i      (mem_ready),
        .block_type_i                 (btype),
        .block0_start_i               (s0),
        .block1_start_i               (s1),
        .block0_length_i              (l0),
        .block1_length_i              (l1),
        .schedule_valid_i             (sched_valid),
        .schedule_ready_o             (sched_ready),
        .block0_unit_o                (unit0),
        .block1_unit_o                (unit1),
        .schedule_done_o              (done)
    );

    always #5 clk = ~clk;

    // Reference decision: {unit1, unit0}.
    function automatic logic [3:0] model_units(input logic [1:0] bt,
            input logic [31:0] len0, len1, d0, d1, npu, cim);
        longint unsigned w0, w1;
        logic [1:0] u0, u1;
        bit b1_npu;
        w0 = (len0 != 0) ? longint'(d0) : 0;
        w1 = (len1 != 0) ? longint'(d1) : 0;
        u0 = 2'd1;
        u1 = 2'd1;
        if (w0 + w1 > longint'(npu)) begin
            if (w0 != w1) b1_npu = (w1 > w0);
            else          b1_npu = (bt == 2'd1);
            if (b1_npu) u0 = (w0 <= longint'(cim)) ? 2'd2 : 2'd1;
            else        u1 = (w1 <= longint'(cim)) ? 2'd2 : 2'd1;
        end
        if (len0 == 0) u0 = 2'd0;
        if (len1 == 0) u1 = 2'd0;
        return {u1, u0};
    endfunction

    // Memory responder and bus/result monitor, all on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            mem_ready  = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (!mem_valid) begin
                chk_cnt++;
                if (mem_addr !== 32'd0) $display("FAIL addr_idle: addr=%0d required 0", mem_addr);
                else pass_cnt++;
            end
            if (prev_valid && !prev_ready) begin
                chk_cnt++;
                if (mem_valid !== 1'b1 || mem_addr !== prev_addr)
                    $display("FAIL req_stable: valid=%0b addr=%0d required valid=1 addr=%0d",
                             mem_valid, mem_addr, prev_addr);
                else pass_cnt++;
            end
            if (prev_valid && prev_ready) begin
                chk_cnt++;
                if (mem_valid !== 1'b0) $display("FAIL valid_drop: valid=%0b required 0", mem_valid);
                else pass_cnt++;
            end
            if (mem_valid) begin
                mem_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
                mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
            end else begin
                // Occasional stray ready with no request outstanding.
                mem_ready = ($urandom_range(0, 5) == 0);
                mem_rdata = $urandom;
            end
            if (mem_valid && mem_ready) begin
                chk_cnt++;
                if (exp_addr.size() == 0) begin
                    $display("FAIL read_addr: unexpected read at addr=%0d", mem_addr);
                end else begin
                    logic [31:0] ea;
                    ea = exp_addr.pop_front();
                    if (mem_addr !== ea) $display("FAIL read_addr: addr=%0d required %0d", mem_addr, ea);
                    else pass_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                chk_cnt++;
                if (prev_done) begin
                    $display("FAIL done_width: done high on consecutive cycles");
                end else if (exp_units.size() == 0) begin
                    $display("FAIL units: unexpected done, units=%0d/%0d", unit0, unit1);
                end else begin
                    logic [3:0] eu;
                    eu = exp_units.pop_front();
                    if ({unit1, unit0} !== eu)
                        $display("FAIL units: block0=%0d block1=%0d required block0=%0d block1=%0d",
                                 unit0, unit1, eu[1:0], eu[3:2]);
                    else pass_cnt++;
                end
            end
            prev_valid = mem_valid;
            prev_ready = mem_ready;
            prev_addr  = mem_addr;
            prev_done  = done;
        end
    end

    task automatic check_reset_state(input string name);
        chk_cnt++;
        if (mem_valid !== 1'b0 || mem_addr !== 32'd0 || sched_ready !== 1'b1 ||
            done !== 1'b0 || unit0 !== 2'd0 || unit1 !== 2'd0)
            $display("FAIL %s: valid=%0b addr=%0d ready=%0b done=%0b units=%0d/%0d required 0/0/1/0/0/0",
                     name, mem_valid, mem_addr, sched_ready, done, unit0, unit1);
        else pass_cnt++;
    endtask

    task automatic run_sched(input logic [1:0] bt, input logic [31:0] a0, a1, n0, n1,
                             d0, d1, npu, cim, input bit junk);
        int base;
        bit got;
        logic [3:0] eu;
        if (n0 != 0) begin mem[a0] = d0; exp_addr.push_back(a0); end
        if (n1 != 0) begin mem[a1] = d1; exp_addr.push_back(a1); end
        eu = model_units(bt, n0, n1, d0, d1, npu, cim);
        exp_units.push_back(eu);
        base = done_cnt;
        @(negedge clk);
        for (int i = 0; i < 50 && !sched_ready; i++) @(negedge clk);
        chk_cnt++;
        if (sched_ready !== 1'b1) $display("FAIL sched_ready: ready=%0b required 1", sched_ready);
        else pass_cnt++;
        btype = bt; s0 = a0; s1 = a1; l0 = n0; l1 = n1; npu_cap = npu; cim_cap = cim;
        sched_valid = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (sched_ready !== 1'b0) $display("FAIL busy_ready: ready=%0b required 0", sched_ready);
        else pass_cnt++;
        // Scramble inputs after acceptance; the run must not notice.
        btype = 2'($urandom); s0 = $urandom; s1 = $urandom; l0 = $urandom; l1 = $urandom;
        npu_cap = $urandom; cim_cap = $urandom;
        if (junk) begin
            @(negedge clk);
            @(negedge clk);
        end
        sched_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > base) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk_cnt++;
        if (!got) $display("FAIL done_timeout: no done within 300 cycles");
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (exp_addr.size() != 0 || {unit1, unit0} !== eu)
            $display("FAIL unit_hold: pending_reads=%0d units=%0d/%0d required 0 and %0d/%0d",
                     exp_addr.size(), unit0, unit1, eu[1:0], eu[3:2]);
        else pass_cnt++;
        $display("run type=%0d len=%0d/%0d data=%0d/%0d npu=%0d cim=%0d -> units %0d/%0d",
                 bt, n0, n1, d0, d1, npu, cim, unit0, unit1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset_state");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_sched(2'd0, 32'd4,  32'd0,  32'd1, 32'd1, 32'd222, 32'd333, 32'd3, 32'd1, 1'b0);
        run_sched(2'd1, 32'd16, 32'd20, 32'd1, 32'd1, 32'd1,   32'd1,   32'd3, 32'd1, 1'b0);
        run_sched(2'd2, 32'd32, 32'd36, 32'd2, 32'd1, 32'd5,   32'd1,   32'd3, 32'd1, 1'b0);
        run_sched(2'd1, 32'd40, 32'd44, 32'd1, 32'd3, 32'd2,   32'd2,   32'd3, 32'd2, 1'b0);
        run_sched(2'd0, 32'd48, 32'd52, 32'd4, 32'd0, 32'd7,   32'd9,   32'd3, 32'd1, 1'b0);
        run_sched(2'd2, 32'd56, 32'd60, 32'd0, 32'd5, 32'd9,   32'd2,   32'd1, 32'd1, 1'b0);
    endtask

    task automatic test_boundaries();
        run_sched(2'd3, 32'd64, 32'd68, 32'd1, 32'd1, 32'd4, 32'd4, 32'd3, 32'd9, 1'b0);
        run_sched(2'd2, 32'd72, 32'd76, 32'd1, 32'd1, 32'd4, 32'd4, 32'd3, 32'd3, 1'b0);
        run_sched(2'd0, 32'd80, 32'd84, 32'd1, 32'd1, 32'd2, 32'd1, 32'd3, 32'd0, 1'b0);
        run_sched(2'd1, 32'd88, 32'd92, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd1,
                  32'hFFFF_FFFF, 32'd1, 1'b0);
        run_sched(2'd0, 32'd96, 32'd100, 32'd0, 32'd0, 32'd5, 32'd5, 32'd3, 32'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            run_sched(2'($urandom), 32'd256 + 32'(8 * k), 32'd260 + 32'(8 * k),
                      32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                      32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                      32'($urandom_range(0, 20)), 32'($urandom_range(0, 10)), 1'(k % 2));
        end
    endtask

    task automatic test_reset_mid_read();
        int base;
        bit seen;
        mem[32'd500] = 32'd9;
        exp_addr.push_back(32'd500);
        hold_ready = 1'b1;
        @(negedge clk);
        btype = 2'd0; s0 = 32'd500; s1 = 32'd504; l0 = 32'd1; l1 = 32'd1;
        npu_cap = 32'd3; cim_cap = 32'd1;
        sched_valid = 1'b1;
        @(negedge clk);
        sched_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk_cnt++;
        if (!seen) $display("FAIL mid_read_valid: valid never rose");
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        check_reset_state("reset_mid_read");
        exp_addr.delete();
        exp_units.delete();
        base = done_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk_cnt++;
        if (done_cnt != base || mem_valid !== 1'b0 || sched_ready !== 1'b1)
            $display("FAIL reset_abandon: done_pulses=%0d valid=%0b ready=%0b required 0/0/1",
                     done_cnt - base, mem_valid, sched_ready);
        else pass_cnt++;
        run_sched(2'd2, 32'd600, 32'd604, 32'd1, 32'd1, 32'd5, 32'd1, 32'd3, 32'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
